// File: rtl/serving_loader.sv
// serving_loader: boot loader in front of the shared SRAM Wishbone port.
//
// After reset the CPU is held in reset while a program image arrives as a byte
// stream: a 16-bit word count N (LSB first), then N little-endian 32-bit words.
// Each word is written to the SRAM starting at word address 0. Once loading
// completes, the SRAM port is handed to the CPU bus and CPU reset is released.
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_rx_*, o_rx_ready     image byte stream (accepted on valid & ready)
//   o_wb_*, i_wb_*         Wishbone master towards the SRAM
//   i_cpu_wb_*, o_cpu_wb_* CPU Wishbone bus, connected to the SRAM once done
//   o_cpu_rst              active-high CPU reset
//   o_done / o_err         image loaded / load failed (both terminal)
//
// Optional feature: define SERVING_LOADER_CHECKSUM_EN to expect one trailing
// byte holding the mod-256 sum of all data bytes; a mismatch ends in error.
module serving_loader #(
  parameter int unsigned depth = 256,
  parameter int unsigned aw    = $clog2(depth)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [7:0]    i_rx_data,
  input  logic          i_rx_valid,
  output logic          o_rx_ready,
  output logic [aw-3:0] o_wb_adr,
  output logic [31:0]   o_wb_dat,
  output logic [3:0]    o_wb_sel,
  output logic          o_wb_we,
  output logic          o_wb_stb,
  input  logic [31:0]   i_wb_rdt,
  input  logic          i_wb_ack,
  input  logic [aw-3:0] i_cpu_wb_adr,
  input  logic [31:0]   i_cpu_wb_dat,
  input  logic [3:0]    i_cpu_wb_sel,
  input  logic          i_cpu_wb_we,
  input  logic          i_cpu_wb_stb,
  output logic [31:0]   o_cpu_wb_rdt,
  output logic          o_cpu_wb_ack,
  output logic          o_cpu_rst,
  output logic          o_done,
  output logic          o_err
);

  localparam logic [15:0] MaxWords = 16'(depth / 4);

`ifdef SERVING_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StHdr0, StHdr1, StData, StWrite, StChk, StDone, StErr} state_e;
  localparam state_e StAfterData = StChk;
`else
  typedef enum logic [2:0] {StHdr0, StHdr1, StData, StWrite, StDone, StErr} state_e;
  localparam state_e StAfterData = StDone;
`endif

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;    // total word count N
  logic [15:0] wadr_q, wadr_d;  // current word address
  logic [1:0]  idx_q, idx_d;    // byte lane within the word
  logic [31:0] dat_q, dat_d;
  logic        stb_q, stb_d;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [7:0]  sum_q, sum_d;
  logic        accept;
  logic [15:0] n_full;
  logic [15:0] wadr_inc;

  assign accept   = i_rx_valid & rdy_q;
  assign n_full   = {i_rx_data, cnt_q[7:0]};
  assign wadr_inc = wadr_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wadr_d  = wadr_q;
    idx_d   = idx_q;
    dat_d   = dat_q;
    stb_d   = stb_q;
    sum_d   = sum_q;
    unique case (state_q)
      StHdr0: begin
        if (accept) begin
          cnt_d[7:0] = i_rx_data;
          state_d    = StHdr1;
        end
      end
      StHdr1: begin
        if (accept) begin
          cnt_d[15:8] = i_rx_data;
          wadr_d      = '0;
          idx_d       = '0;
          sum_d       = '0;
          if (n_full == 16'd0)       state_d = StAfterData;
          else if (n_full > MaxWords) state_d = StErr;
          else                        state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          dat_d[8*idx_q +: 8] = i_rx_data;
          idx_d = idx_q + 2'd1;
          sum_d = sum_q + i_rx_data;
          if (idx_q == 2'd3) begin
            stb_d   = 1'b1;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        // Bus signals hold until ack; strobe must be low the cycle after.
        if (i_wb_ack) begin
          stb_d   = 1'b0;
          wadr_d  = wadr_inc;
          state_d = (wadr_inc == cnt_q) ? StAfterData : StData;
        end
      end
`ifdef SERVING_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) state_d = (i_rx_data == sum_q) ? StDone : StErr;
      end
`endif
      StDone: ;
      StErr:  ;
      default: state_d = StErr;
    endcase

    rdy_d  = (state_d != StWrite) && (state_d != StDone);
    done_d = (state_d == StDone);
    err_d  = (state_d == StErr);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StHdr0;
      cnt_q   <= '0;
      wadr_q  <= '0;
      idx_q   <= '0;
      dat_q   <= '0;
      stb_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wadr_q  <= wadr_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      sum_q   <= sum_d;
    end
  end

  // done_q is the registered bus-ownership select.
  always_comb begin
    if (done_q) begin
      o_wb_adr     = i_cpu_wb_adr;
      o_wb_dat     = i_cpu_wb_dat;
      o_wb_sel     = i_cpu_wb_sel;
      o_wb_we      = i_cpu_wb_we;
      o_wb_stb     = i_cpu_wb_stb;
      o_cpu_wb_ack = i_wb_ack;
      o_cpu_wb_rdt = i_wb_rdt;
    end else begin
      o_wb_adr     = wadr_q[aw-3:0];
      o_wb_dat     = dat_q;
      o_wb_sel     = {4{stb_q}};
      o_wb_we      = stb_q;
      o_wb_stb     = stb_q;
      o_cpu_wb_ack = 1'b0;
      o_cpu_wb_rdt = '0;
    end
  end

  assign o_rx_ready = rdy_q;
  assign o_cpu_rst  = ~done_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: doc/serving_loader.md
Name: serving_loader

Overview:
- Boot loader stage directly upstream of the shared RF/instruction/data SRAM's Wishbone port.
- After reset, holds the CPU in reset, receives a program image as a byte stream (typically from the UART RX), packs it into 32-bit little-endian words and writes them to the SRAM from address 0.
- Once loading completes, hands the SRAM Wishbone port to the CPU bus via a registered-select mux and releases CPU reset.

Parameters:
- depth, 256: SRAM depth in bytes; must match the SRAM instance.
- aw, $clog2(depth): byte address width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_rx_data  in  8  incoming image byte
- i_rx_valid  in  1  byte valid
- o_rx_ready  out  1  byte accepted when valid & ready
- o_wb_adr  out  aw-2  word address to SRAM
- o_wb_dat  out  32  write data to SRAM
- o_wb_sel  out  4  byte selects to SRAM
- o_wb_we  out  1  write enable to SRAM
- o_wb_stb  out  1  strobe to SRAM
- i_wb_rdt  in  32  SRAM read data
- i_wb_ack  in  1  SRAM ack (one-cycle pulse)
- i_cpu_wb_adr  in  aw-2  CPU bus address
- i_cpu_wb_dat  in  32  CPU write data
- i_cpu_wb_sel  in  4  CPU byte selects
- i_cpu_wb_we  in  1  CPU write enable
- i_cpu_wb_stb  in  1  CPU strobe
- o_cpu_wb_rdt  out  32  read data to CPU
- o_cpu_wb_ack  out  1  ack to CPU
- o_cpu_rst  out  1  active-high CPU reset
- o_done  out  1  image loaded, CPU owns the bus
- o_err  out  1  load failed

Behaviour:
- Reset values: o_rx_ready=0, o_wb_stb=0, o_wb_we=0, o_wb_adr=0, o_wb_dat=0, o_wb_sel=0, o_cpu_rst=1, o_done=0, o_err=0, o_cpu_wb_ack=0. The state machine resets to HDR0.
- Image format: 2-byte word count N (LSB first), then N×4 data bytes, each word LSB first.
- HDR0: rx_ready=1. On accept, latch N[7:0] and go to HDR1.
- HDR1: rx_ready=1. On accept, latch N[15:8], then:
  - N==0 → DONE.
  - N > depth/4 → ERR.
  - otherwise → DATA, with word address 0 and byte index 0.
- DATA: rx_ready=1. Each accepted byte goes to word byte lane [idx]; idx increments mod 4. On acceptance of the 4th byte → WRITE, with o_wb_stb=1, o_wb_we=1, o_wb_sel=4'hF and o_wb_adr set to the word address, all registered.
- WRITE:
  - rx_ready=0; stb, we, adr and dat are held stable until i_wb_ack.
  - The cycle after ack, stb is 0 (the SRAM requires stb low after ack).
  - The word address increments. If that was the N-th word → DONE, otherwise → DATA.
  - The SRAM takes ≥5 cycles per word; no write ever overlaps the next byte collection.
- DONE:
  - o_done=1 and o_cpu_rst=0, registered, in the cycle after entry.
  - o_wb_* = i_cpu_wb_* combinationally; o_cpu_wb_ack = i_wb_ack; o_cpu_wb_rdt = i_wb_rdt.
  - rx_ready=0. DONE is terminal until reset.
- Before DONE: o_cpu_wb_ack=0, o_cpu_wb_rdt=0, and CPU stb is ignored.
- ERR: o_err=1, rx_ready=1 (the stream is drained and discarded), CPU held in reset and SRAM stb=0. Terminal until reset.
- Word counter width: 16 bits; the address is the low aw-2 bits. N == depth/4 exactly is legal and fills the SRAM.
- An i_rx_valid byte presented in the same cycle as the final ack is not accepted (rx_ready=0 in WRITE).
- Asynchronous reset mid-load: stb drops immediately, the CPU re-enters reset, the state machine returns to HDR0, and partially written SRAM contents are left as is.

Optional Feature:
- Macro: SERVING_LOADER_CHECKSUM_EN.
- Defined:
  - One extra byte follows the data: the 8-bit sum (mod 256) of all N×4 data bytes.
  - After the last word's ack, enter CHK with rx_ready=1.
  - On accept: match → DONE; mismatch → ERR.
  - For N==0 a checksum byte is still expected and must be 8'h00.
- Undefined: there is no CHK state and the behaviour is as above.

Test Plan:
- Reset, then send 01 00 EF BE AD DE → one SRAM write, adr=0, dat=32'hDEADBEEF, sel=F. The cycle after ack, o_done=1 and o_cpu_rst=0.
- Send 03 00 plus 12 bytes 00..0B, with the ack stub delaying 5 cycles → writes 32'h03020100@0, 32'h07060504@1, 32'h0B0A0908@2. stb is held constant until each ack, and o_rx_ready=0 during every WRITE.
- Send header 41 00 (65 > 64 with depth=256) → o_err=1, o_rx_ready stays 1, o_cpu_rst stays 1, and no SRAM strobe occurs.
- Send header 00 00 → o_done the cycle after HDR1. Then a CPU read stb at adr 5 → o_wb_stb/adr follow the CPU, and the SRAM ack and rdt are returned to the CPU.
- Deassert i_rst_n during the second word's WRITE → o_wb_stb=0 and o_cpu_rst=1 immediately. After release, the full image reloads correctly.
- With SERVING_LOADER_CHECKSUM_EN: image 01 00 01 02 03 04 plus checksum 0A → done. Same image with checksum 0B → o_err=1 and CPU stays in reset.
